ecc_status_apb_ctrl: RTL and testbench
======================================

Name: ecc_status_apb_ctrl

Overview:
- Sequencer between the FIFO read-path ECC decoder and the APB register file.
- Takes per-read ECC event pulses and keeps saturating single-bit error (SBE) and double-bit error (DBE) counters.
- Issues proper two-phase APB write transactions (SETUP, then ACCESS, waiting on pready) to the ECC status, SBE-count and DBE-count registers.
- Owns the sticky ECC interrupt.

Parameters:
- DATA_WIDTH, 32, APB write data width.
- REG_ADDR_WIDTH, 10, APB address width.
- CNT_WIDTH, 16, SBE/DBE counter width (≤ DATA_WIDTH).
- ECC_STATUS_REG_ADDR, 10'd0, status register address.
- ECC_SBE_CNT_REG_ADDR, 10'd4, SBE counter register address.
- ECC_DBE_CNT_REG_ADDR, 10'd8, DBE counter register address.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- ecc_evt_valid  in  1  one-cycle pulse per ECC-checked read.
- ecc_evt_type  in  2  0 = none, 1 = SBE, 2 = DBE, 3 = reserved (treated as none).
- ECC_irq_en  in  1  enables interrupt on DBE.
- irq_clr  in  1  pulse that clears the sticky interrupt.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  always 1 while o_psel = 1, else 0.
- o_paddr  out  REG_ADDR_WIDTH  APB address.
- o_pwdata  out  DATA_WIDTH  APB write data.
- o_pstrb  out  4  4'b1111 while o_psel = 1, else 0.
- i_pready  in  1  APB ready.
- i_pslverr  in  1  APB slave error.
- ECC_interrupt  out  1  sticky DBE interrupt.
- sbe_cnt  out  CNT_WIDTH  live SBE count.
- dbe_cnt  out  CNT_WIDTH  live DBE count.
- apb_err  out  1  sticky: a pslverr was seen.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert): every output is 0, counters are 0, pending flags are clear, FSM is in IDLE. An in-flight APB transfer is abandoned and not replayed.
- Event capture, on a clk edge with ecc_evt_valid = 1:
  - type 1 increments sbe_cnt, saturating at all-ones.
  - type 2 increments dbe_cnt, saturating at all-ones.
  - type 0, 1 or 2 sets pend_status and records last_type. Type 3 is treated as none but still sets pend_status.
  - type 1 sets pend_sbe; type 2 sets pend_dbe.
  - Counters are visible one cycle after the event.
- Sticky status bits: sbe_seen (bit 3) and dbe_seen (bit 2). Both are cleared only by rst.
- Status word: {zeros, sbe_seen, dbe_seen, last_type[1:0]}.
- FSM states: IDLE → SETUP → ACCESS → IDLE.
  - IDLE: if any pending flag is set, select the highest-priority target (status > SBE-count > DBE-count). Latch o_paddr and o_pwdata from the snapshot, clear that target's pending flag, go to SETUP.
  - SETUP: o_psel = 1, o_penable = 0; exactly one cycle; then go to ACCESS.
  - ACCESS: o_psel = 1, o_penable = 1. Hold until i_pready = 1, then go to IDLE. If i_pslverr = 1 in that same cycle, set apb_err. Writes are not retried.
- Latency: an event at edge N gives o_psel = 1 after edge N+1 and o_penable = 1 after edge N+2.
- Back-to-back transfers: a new SETUP starts one cycle after ACCESS completes (IDLE is visited for one cycle).
- o_paddr and o_pwdata are stable from SETUP through ACCESS completion. Counter values are zero-extended to DATA_WIDTH.
- Coalescing:
  - An event arriving while a transfer is in flight updates the counters and re-sets the pending flags, so the value written later is the latest.
  - An event arriving in the same cycle a target's flag is cleared re-sets that flag (set wins).
  - Repeated events to an already-pending target produce a single write.
- Interrupt:
  - Set on a DBE event when ECC_irq_en = 1.
  - Cleared by irq_clr.
  - A simultaneous DBE event and irq_clr leaves it set (set wins).
  - ECC_irq_en = 0 does not clear an already-set interrupt.
- busy = (state != IDLE).

Decomposition:
- Package ecc_ctrl_pkg holds:
  - typedef enum for the FSM state {IDLE, SETUP, ACCESS};
  - typedef enum for the event type {ECC_NONE, ECC_SBE, ECC_DBE};
  - the status-word bit-position constants.
- One natural sub-module: ecc_sat_counter (parameterised saturating up-counter with enable), instantiated twice.

Test Plan:
- Reset then idle, i_pready = 1: all outputs stay 0, busy = 0 for 20 cycles.
- Single SBE event, i_pready = 1:
  - status write: o_paddr = 0, o_pwdata = 32'h9, psel at N+1, penable at N+2;
  - then SBE-count write: o_paddr = 4, o_pwdata = 1;
  - sbe_cnt = 1; no DBE-count write.
- DBE event with ECC_irq_en = 1, i_pready held low for 3 ACCESS cycles:
  - ECC_interrupt = 1;
  - o_paddr and o_pwdata are stable through the wait;
  - writes in order: status = 32'h6, then DBE count = 1.
- DBE event and irq_clr in the same cycle → ECC_interrupt stays 1. A later irq_clr alone → 0.
- 5 SBE events during one stalled transfer → exactly one SBE-count write, with o_pwdata = 5.
- CNT_WIDTH = 4, 20 SBE events → sbe_cnt saturates at 15.
- ACCESS with i_pready = 1 and i_pslverr = 1 → apb_err = 1 and stays 1 until rst.
- rst asserted mid-ACCESS → o_psel and o_penable drop to 0 immediately (async); no resumed transfer after rst is released.

Source files
------------

// File: rtl/ecc_ctrl_pkg.sv
// rtl/ecc_ctrl_pkg.sv - shared types and status-word layout for the ECC status sequencer
package ecc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    ECC_NONE = 2'd0,
    ECC_SBE  = 2'd1,
    ECC_DBE  = 2'd2
  } ecc_evt_e;

  localparam int STAT_LAST_TYPE_LSB = 0;
  localparam int STAT_DBE_SEEN_BIT  = 2;
  localparam int STAT_SBE_SEEN_BIT  = 3;

endpackage

// File: rtl/ecc_sat_counter.sv
// rtl/ecc_sat_counter.sv - saturating up-counter with enable
module ecc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_status_apb_ctrl.sv
// rtl/ecc_status_apb_ctrl.sv - ECC event counters, sticky irq and APB write sequencer
import ecc_ctrl_pkg::*;

module ecc_status_apb_ctrl #(
  parameter int                        DATA_WIDTH           = 32,
  parameter int                        REG_ADDR_WIDTH       = 10,
  parameter int                        CNT_WIDTH            = 16,
  parameter logic [REG_ADDR_WIDTH-1:0] ECC_STATUS_REG_ADDR  = REG_ADDR_WIDTH'(0),
  parameter logic [REG_ADDR_WIDTH-1:0] ECC_SBE_CNT_REG_ADDR = REG_ADDR_WIDTH'(4),
  parameter logic [REG_ADDR_WIDTH-1:0] ECC_DBE_CNT_REG_ADDR = REG_ADDR_WIDTH'(8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ecc_evt_valid,
  input  logic [1:0]                ecc_evt_type,
  input  logic                      ECC_irq_en,
  input  logic                      irq_clr,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [REG_ADDR_WIDTH-1:0] o_paddr,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [3:0]                o_pstrb,
  input  logic                      i_pready,
  input  logic                      i_pslverr,
  output logic                      ECC_interrupt,
  output logic [CNT_WIDTH-1:0]      sbe_cnt,
  output logic [CNT_WIDTH-1:0]      dbe_cnt,
  output logic                      apb_err,
  output logic                      busy
);

  apb_state_e state, state_nxt;

  logic evt_sbe, evt_dbe;
  logic sbe_seen, dbe_seen;
  logic [1:0] last_type;
  logic pend_status, pend_sbe, pend_dbe;
  logic clr_status, clr_sbe, clr_dbe, load;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic [DATA_WIDTH-1:0]     status_word;

  assign evt_sbe = ecc_evt_valid && (ecc_evt_type == ECC_SBE);
  assign evt_dbe = ecc_evt_valid && (ecc_evt_type == ECC_DBE);

  ecc_sat_counter #(.W(CNT_WIDTH)) u_sbe_cnt (
    .clk (clk),
    .rst (rst),
    .en  (evt_sbe),
    .cnt (sbe_cnt)
  );

  ecc_sat_counter #(.W(CNT_WIDTH)) u_dbe_cnt (
    .clk (clk),
    .rst (rst),
    .en  (evt_dbe),
    .cnt (dbe_cnt)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_SBE_SEEN_BIT] = sbe_seen;
    status_word[STAT_DBE_SEEN_BIT] = dbe_seen;
    status_word[STAT_LAST_TYPE_LSB +: 2] = last_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority pick in IDLE: status first, then SBE count, then DBE count.
  always_comb begin
    state_nxt  = state;
    clr_status = 1'b0;
    clr_sbe    = 1'b0;
    clr_dbe    = 1'b0;
    load       = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    case (state)
      IDLE: begin
        if (pend_status) begin
          clr_status = 1'b1;
          load       = 1'b1;
          sel_addr   = ECC_STATUS_REG_ADDR;
          sel_data   = status_word;
        end else if (pend_sbe) begin
          clr_sbe  = 1'b1;
          load     = 1'b1;
          sel_addr = ECC_SBE_CNT_REG_ADDR;
          sel_data = DATA_WIDTH'(sbe_cnt);
        end else if (pend_dbe) begin
          clr_dbe  = 1'b1;
          load     = 1'b1;
          sel_addr = ECC_DBE_CNT_REG_ADDR;
          sel_data = DATA_WIDTH'(dbe_cnt);
        end
        if (load) state_nxt = SETUP;
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (i_pready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new event in the clearing cycle re-arms its flag (set wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_status   <= 1'b0;
      pend_sbe      <= 1'b0;
      pend_dbe      <= 1'b0;
      sbe_seen      <= 1'b0;
      dbe_seen      <= 1'b0;
      last_type     <= 2'd0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
      apb_err       <= 1'b0;
      ECC_interrupt <= 1'b0;
    end else begin
      pend_status <= (pend_status && !clr_status) || ecc_evt_valid;
      pend_sbe    <= (pend_sbe && !clr_sbe) || evt_sbe;
      pend_dbe    <= (pend_dbe && !clr_dbe) || evt_dbe;
      sbe_seen    <= sbe_seen || evt_sbe;
      dbe_seen    <= dbe_seen || evt_dbe;
      if (ecc_evt_valid) begin
        last_type <= (ecc_evt_type == 2'd3) ? 2'(ECC_NONE) : ecc_evt_type;
      end
      if (load) begin
        o_paddr  <= sel_addr;
        o_pwdata <= sel_data;
      end
      if ((state == ACCESS) && i_pready && i_pslverr) begin
        apb_err <= 1'b1;
      end
      if (evt_dbe && ECC_irq_en) begin
        ECC_interrupt <= 1'b1;
      end else if (irq_clr) begin
        ECC_interrupt <= 1'b0;
      end
    end
  end

  assign o_psel    = (state != IDLE);
  assign o_penable = (state == ACCESS);
  assign o_pwrite  = o_psel;
  assign o_pstrb   = {4{o_psel}};
  assign busy      = o_psel;

endmodule

// File: tb/tb_ecc_status_apb_ctrl.sv
// tb/tb_ecc_status_apb_ctrl.sv - directed bench for ecc_status_apb_ctrl with event-count model
module tb_ecc_status_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ecc_evt_valid = 1'b0;
  logic [1:0]  ecc_evt_type = 2'd0;
  logic        ECC_irq_en = 1'b0;
  logic        irq_clr = 1'b0;
  logic        i_pready = 1'b1;
  logic        i_pslverr = 1'b0;

  logic        o_psel, o_penable, o_pwrite;
  logic [9:0]  o_paddr;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        ECC_interrupt, apb_err, busy;
  logic [15:0] sbe_cnt, dbe_cnt;

  logic        psel4, penable4, pwrite4, irq4, err4, busy4;
  logic [9:0]  paddr4;
  logic [31:0] pwdata4;
  logic [3:0]  pstrb4;
  logic [3:0]  sbe_cnt4, dbe_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ecc_status_apb_ctrl dut (
    .clk(clk), .rst(rst), .ecc_evt_valid(ecc_evt_valid), .ecc_evt_type(ecc_evt_type),
    .ECC_irq_en(ECC_irq_en), .irq_clr(irq_clr), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_paddr(o_paddr), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .ECC_interrupt(ECC_interrupt),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .apb_err(apb_err), .busy(busy)
  );

  ecc_status_apb_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ecc_evt_valid(ecc_evt_valid), .ecc_evt_type(ecc_evt_type),
    .ECC_irq_en(ECC_irq_en), .irq_clr(irq_clr), .o_psel(psel4), .o_penable(penable4),
    .o_pwrite(pwrite4), .o_paddr(paddr4), .o_pwdata(pwdata4), .o_pstrb(pstrb4),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .ECC_interrupt(irq4),
    .sbe_cnt(sbe_cnt4), .dbe_cnt(dbe_cnt4), .apb_err(err4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  // Model: event counts since reset, sticky irq/err, and a log of completed writes.
  int   n_sbe = 0, n_dbe = 0;
  logic m_irq = 1'b0, m_err = 1'b0;
  logic neg_err = 1'b0;
  logic prev_setup = 1'b0;
  logic [9:0]  hold_a;
  logic [31:0] hold_d;
  int   wr_addr[$];
  int   wr_data[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_sbe = 0; n_dbe = 0; m_irq = 1'b0; m_err = 1'b0;
    end else begin
      if (ecc_evt_valid && ecc_evt_type == 2'd1) n_sbe++;
      if (ecc_evt_valid && ecc_evt_type == 2'd2) n_dbe++;
      if (ecc_evt_valid && ecc_evt_type == 2'd2 && ECC_irq_en) m_irq = 1'b1;
      else if (irq_clr) m_irq = 1'b0;
      if (neg_err) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("sbe_cnt", 64'(sbe_cnt), 64'(sat(n_sbe, 65535)));
    chk("dbe_cnt", 64'(dbe_cnt), 64'(sat(n_dbe, 65535)));
    chk("sbe_cnt_w4", 64'(sbe_cnt4), 64'(sat(n_sbe, 15)));
    chk("irq", 64'(ECC_interrupt), 64'(m_irq));
    chk("apb_err", 64'(apb_err), 64'(m_err));
    chk("pwrite", 64'(o_pwrite), 64'(o_psel));
    chk("busy", 64'(busy), 64'(o_psel));
    chk("pstrb", 64'(o_pstrb), o_psel ? 64'hf : 64'h0);
    if (o_penable) chk("penable_wo_psel", 64'(o_psel), 64'd1);
    if (prev_setup && !rst) chk("setup_one_cycle", 64'(o_penable), 64'd1);
    if (o_psel && !o_penable) begin
      hold_a = o_paddr;
      hold_d = o_pwdata;
    end else if (o_psel && o_penable) begin
      chk("paddr_stable", 64'(o_paddr), 64'(hold_a));
      chk("pwdata_stable", 64'(o_pwdata), 64'(hold_d));
    end
    neg_err = 1'b0;
    if (o_psel && o_penable && i_pready) begin
      wr_addr.push_back(int'(o_paddr));
      wr_data.push_back(int'(o_pwdata));
      neg_err = i_pslverr;
    end
    prev_setup = o_psel && !o_penable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] t, input logic clr);
    ecc_evt_valid = 1'b1;
    ecc_evt_type  = t;
    irq_clr       = clr;
    tick();
    ecc_evt_valid = 1'b0;
    ecc_evt_type  = 2'd0;
    irq_clr       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_penable();
    int k = 0;
    while (!o_penable && k < 20) begin tick(); k++; end
    chk("wait_penable_timeout", 64'(o_penable), 64'd1);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < 300) begin
      tick();
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk("wait_idle_timeout", 64'(quiet >= 3), 64'd1);
  endtask

  task automatic exp_wr(input string name, input int idx, input int a, input int d);
    if (idx < wr_addr.size()) begin
      chk({name, "_addr"}, 64'(wr_addr[idx]), 64'(a));
      chk({name, "_data"}, 64'(wr_data[idx]), 64'(d));
    end else begin
      chk({name, "_missing"}, 64'(wr_addr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int base;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      chk("idle_psel", 64'(o_psel), 64'd0);
      chk("idle_penable", 64'(o_penable), 64'd0);
      chk("idle_paddr", 64'(o_paddr), 64'd0);
      chk("idle_pwdata", 64'(o_pwdata), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      tick();
    end

    // Single SBE: status 0x9 then SBE count 1.
    base = wr_addr.size();
    pulse(2'd1, 1'b0);
    chk("sbe_lat_n", 64'(o_psel), 64'd0);
    tick();
    chk("sbe_lat_psel", 64'(o_psel), 64'd1);
    chk("sbe_lat_penable0", 64'(o_penable), 64'd0);
    chk("sbe_setup_addr", 64'(o_paddr), 64'd0);
    chk("sbe_setup_data", 64'(o_pwdata), 64'h9);
    tick();
    chk("sbe_lat_penable1", 64'(o_penable), 64'd1);
    wait_idle();
    chk("sbe_nwrites", 64'(wr_addr.size() - base), 64'd2);
    exp_wr("sbe_w0", base, 0, 9);
    exp_wr("sbe_w1", base + 1, 4, 1);
    chk("sbe_cnt_lit", 64'(sbe_cnt), 64'd1);

    // DBE with irq enabled and a stalled ACCESS.
    do_reset();
    base = wr_addr.size();
    ECC_irq_en = 1'b1;
    i_pready = 1'b0;
    pulse(2'd2, 1'b0);
    chk("dbe_irq_lit", 64'(ECC_interrupt), 64'd1);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("dbe_stall_penable", 64'(o_penable), 64'd1);
    chk("dbe_stall_addr", 64'(o_paddr), 64'd0);
    chk("dbe_stall_data", 64'(o_pwdata), 64'h6);
    i_pready = 1'b1;
    wait_idle();
    chk("dbe_nwrites", 64'(wr_addr.size() - base), 64'd2);
    exp_wr("dbe_w0", base, 0, 6);
    exp_wr("dbe_w1", base + 1, 8, 1);

    // Interrupt set-wins, enable drop does not clear, clear alone.
    do_reset();
    pulse(2'd2, 1'b1);
    chk("irq_setwins", 64'(ECC_interrupt), 64'd1);
    ECC_irq_en = 1'b0;
    tick();
    chk("irq_en_off_holds", 64'(ECC_interrupt), 64'd1);
    pulse(2'd0, 1'b1);
    chk("irq_cleared", 64'(ECC_interrupt), 64'd0);
    pulse(2'd2, 1'b0);
    chk("irq_disabled_dbe", 64'(ECC_interrupt), 64'd0);
    wait_idle();

    // Five SBEs during one stalled transfer coalesce into one count write.
    do_reset();
    base = wr_addr.size();
    i_pready = 1'b0;
    pulse(2'd0, 1'b0);
    wait_penable();
    for (int i = 0; i < 5; i++) pulse(2'd1, 1'b0);
    i_pready = 1'b1;
    wait_idle();
    chk("coal_nwrites", 64'(wr_addr.size() - base), 64'd3);
    exp_wr("coal_w0", base, 0, 0);
    exp_wr("coal_w1", base + 1, 0, 9);
    exp_wr("coal_w2", base + 2, 4, 5);

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 20; i++) pulse(2'd1, 1'b0);
    chk("sat_cnt4", 64'(sbe_cnt4), 64'd15);
    chk("sat_cnt16", 64'(sbe_cnt), 64'd20);
    wait_idle();

    // Slave error is sticky until reset.
    do_reset();
    i_pslverr = 1'b1;
    pulse(2'd0, 1'b0);
    wait_idle();
    chk("pslverr_set", 64'(apb_err), 64'd1);
    i_pslverr = 1'b0;
    pulse(2'd1, 1'b0);
    wait_idle();
    chk("pslverr_sticky", 64'(apb_err), 64'd1);

    // Async reset in the middle of ACCESS.
    do_reset();
    chk("err_after_rst", 64'(apb_err), 64'd0);
    base = wr_addr.size();
    i_pready = 1'b0;
    pulse(2'd1, 1'b0);
    wait_penable();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_psel", 64'(o_psel), 64'd0);
    chk("rst_async_penable", 64'(o_penable), 64'd0);
    tick();
    rst = 1'b0;
    i_pready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("rst_no_replay", 64'(o_psel), 64'd0);
    end
    chk("rst_nwrites", 64'(wr_addr.size() - base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
